// File: rtl/frame_config_writer.sv
// frame_config_writer
//   Transmit side of the tile configuration interface at the bottom of a
//   fabric column. Accepts a word stream of frame commands (one header word
//   followed by one data word per row), drives the row-indexed FrameData bus
//   and then raises exactly one FrameStrobe bit for one cycle so that every
//   row latches its frame together. FrameData is held one further cycle after
//   the strobe for latch hold time.
//
// Ports
//   UserCLK      in   clock, rising edge
//   resetn       in   asynchronous reset, active low
//   s_data       in   command/data stream word (FrameBitsPerRow bits)
//   s_valid      in   s_data valid
//   s_ready      out  writer accepts s_data this cycle
//   FrameData    out  row r at [r*FrameBitsPerRow +: FrameBitsPerRow]
//   FrameStrobe  out  one-hot frame write strobe (MaxFramesPerCol bits)
//   frame_done   out  one-cycle pulse, a frame was strobed
//   frame_err    out  one-cycle pulse, header rejected or index out of range
//   frame_count  out  frames successfully strobed since reset (wraps)
//
// Header word layout: [31:16] = 16'hFAB1 magic, [15:0] = frame index.

module frame_config_writer #(
    parameter int FrameBitsPerRow = 32,
    parameter int MaxFramesPerCol = 32,
    parameter int NumRows         = 4
) (
    input  logic                               UserCLK,
    input  logic                               resetn,
    input  logic [FrameBitsPerRow-1:0]         s_data,
    input  logic                               s_valid,
    output logic                               s_ready,
    output logic [NumRows*FrameBitsPerRow-1:0] FrameData,
    output logic [MaxFramesPerCol-1:0]         FrameStrobe,
    output logic                               frame_done,
    output logic                               frame_err,
    output logic [15:0]                        frame_count
);

    localparam int ROW_W = (NumRows > 1) ? $clog2(NumRows) : 1;
    localparam int IDX_W = (MaxFramesPerCol > 1) ? $clog2(MaxFramesPerCol) : 1;

    localparam logic [15:0]                MAGIC      = 16'hFAB1;
    localparam logic [15:0]                IDX_LIMIT  = 16'(MaxFramesPerCol);
    localparam logic [ROW_W-1:0]           LAST_ROW   = ROW_W'(NumRows - 1);
    localparam logic [ROW_W-1:0]           ROW_ONE    = {{(ROW_W-1){1'b0}}, 1'b1};
    localparam logic [MaxFramesPerCol-1:0] STROBE_ONE = {{(MaxFramesPerCol-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_STROBE = 2'd2,
        ST_HOLD   = 2'd3
    } state_t;

    state_t                       state_r;
    state_t                       state_nxt_s;
    logic                         xfer_s;
    logic                         hdr_ok_s;
    logic                         hdr_bad_idx_s;
    logic                         hdr_take_s;
    logic                         row_wr_s;
    logic                         ready_nxt_s;
    logic [MaxFramesPerCol-1:0]   strobe_nxt_s;
    logic                         done_nxt_s;
    logic                         err_nxt_s;

    logic [IDX_W-1:0]             idx_r;
    logic                         bad_r;
    logic [ROW_W-1:0]             row_r;
    logic [FrameBitsPerRow-1:0]   rows_r [NumRows];
    logic                         s_ready_r;
    logic [MaxFramesPerCol-1:0]   strobe_r;
    logic                         done_r;
    logic                         err_r;
    logic [15:0]                  frame_count_r;

    assign xfer_s        = s_valid & s_ready_r;
    assign hdr_ok_s      = (s_data[31:16] == MAGIC);
    assign hdr_bad_idx_s = (s_data[15:0] >= IDX_LIMIT);
    // s_ready is registered, so it is derived from where the FSM is heading.
    assign ready_nxt_s   = (state_nxt_s == ST_IDLE) || (state_nxt_s == ST_LOAD);

    // Next-state and next-output decode for the frame FSM.
    always_comb begin
        state_nxt_s  = state_r;
        hdr_take_s   = 1'b0;
        row_wr_s     = 1'b0;
        strobe_nxt_s = '0;
        done_nxt_s   = 1'b0;
        err_nxt_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (xfer_s) begin
                    if (hdr_ok_s) begin
                        hdr_take_s  = 1'b1;
                        state_nxt_s = ST_LOAD;
                    end else begin
                        err_nxt_s   = 1'b1;
                        state_nxt_s = ST_IDLE;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (xfer_s) begin
                    row_wr_s = 1'b1;
                    if (row_r == LAST_ROW) begin
                        // A bad-index frame still swallows all its rows so the
                        // stream stays aligned on the next header.
                        if (!bad_r) begin
                            state_nxt_s  = ST_STROBE;
                            strobe_nxt_s = STROBE_ONE << idx_r;
                        end else begin
                            state_nxt_s = ST_IDLE;
                            err_nxt_s   = 1'b1;
                        end
                    end else begin
                        state_nxt_s = ST_LOAD;
                    end
                end else begin
                    state_nxt_s = ST_LOAD;
                end
            end
            ST_STROBE: begin
                state_nxt_s = ST_HOLD;
                done_nxt_s  = 1'b1;
            end
            ST_HOLD: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // FSM state and registered handshake/status outputs.
    always_ff @(posedge UserCLK or negedge resetn) begin
        if (!resetn) begin
            state_r       <= ST_IDLE;
            s_ready_r     <= 1'b0;
            strobe_r      <= '0;
            done_r        <= 1'b0;
            err_r         <= 1'b0;
            frame_count_r <= 16'd0;
        end else begin
            state_r       <= state_nxt_s;
            s_ready_r     <= ready_nxt_s;
            strobe_r      <= strobe_nxt_s;
            done_r        <= done_nxt_s;
            err_r         <= err_nxt_s;
            frame_count_r <= frame_count_r + (done_nxt_s ? 16'd1 : 16'd0);
        end
    end

    // Header fields and row pointer for the frame being loaded.
    always_ff @(posedge UserCLK or negedge resetn) begin
        if (!resetn) begin
            idx_r <= '0;
            bad_r <= 1'b0;
            row_r <= '0;
        end else if (hdr_take_s) begin
            idx_r <= s_data[IDX_W-1:0];
            bad_r <= hdr_bad_idx_s;
            row_r <= '0;
        end else if (row_wr_s) begin
            row_r <= row_r + ROW_ONE;
        end
    end

    // Row data registers; only written by LOAD transfers.
    always_ff @(posedge UserCLK or negedge resetn) begin
        if (!resetn) begin
            for (int r = 0; r < NumRows; r++) begin
                rows_r[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NumRows; r++) begin
                if (row_wr_s && (row_r == ROW_W'(r))) begin
                    rows_r[r] <= s_data;
                end
            end
        end
    end

    for (genvar g = 0; g < NumRows; g++) begin : g_frame_data
        assign FrameData[g*FrameBitsPerRow +: FrameBitsPerRow] = rows_r[g];
    end

    assign s_ready     = s_ready_r;
    assign FrameStrobe = strobe_r;
    assign frame_done  = done_r;
    assign frame_err   = err_r;
    assign frame_count = frame_count_r;

endmodule

// File: tb/tb_frame_config_writer.sv
// Bench for frame_config_writer: a directed vector table, hand-written reset
// and counter-wrap sequences, and randomized frames, all compared each cycle
// against a frame-level reference model.
module tb_frame_config_writer;

    localparam int FB = 32;
    localparam int MF = 32;
    localparam int NR = 4;

    logic               UserCLK = 1'b0;
    logic               resetn;
    logic [FB-1:0]      s_data;
    logic               s_valid;
    logic               s_ready;
    logic [NR*FB-1:0]   FrameData;
    logic [MF-1:0]      FrameStrobe;
    logic               frame_done;
    logic               frame_err;
    logic [15:0]        frame_count;

    int n_vec = 0;
    int n_err = 0;

    always #5 UserCLK = ~UserCLK;

    frame_config_writer #(
        .FrameBitsPerRow(FB),
        .MaxFramesPerCol(MF),
        .NumRows(NR)
    ) dut (
        .UserCLK(UserCLK),
        .resetn(resetn),
        .s_data(s_data),
        .s_valid(s_valid),
        .s_ready(s_ready),
        .FrameData(FrameData),
        .FrameStrobe(FrameStrobe),
        .frame_done(frame_done),
        .frame_err(frame_err),
        .frame_count(frame_count)
    );

    // Reference model: counts words of the current command, remembers the
    // rows, and counts down the two post-frame cycles when input is refused.
    logic [31:0] m_rows [NR];
    int          m_got;     // words of current command taken (0 = expecting header)
    int          m_busy;    // cycles left with input refused after a good frame
    logic [15:0] m_idx;
    logic [15:0] m_count;
    logic        m_ready, m_done, m_err;
    logic [31:0] m_strobe;

    task automatic model_reset();
        for (int r = 0; r < NR; r++) m_rows[r] = 32'h0;
        m_got = 0; m_busy = 0; m_idx = 16'h0; m_count = 16'h0;
        m_ready = 1'b0; m_done = 1'b0; m_err = 1'b0; m_strobe = 32'h0;
    endtask

    task automatic model_edge(input logic v, input logic [31:0] d);
        logic xfer;
        xfer = v && m_ready;
        m_strobe = 32'h0; m_done = 1'b0; m_err = 1'b0;
        if (m_busy == 2) begin
            m_busy = 1; m_done = 1'b1; m_count = m_count + 16'd1;
        end else if (m_busy == 1) begin
            m_busy = 0;
        end else if (xfer) begin
            if (m_got == 0) begin
                if (d[31:16] == 16'hFAB1) begin m_idx = d[15:0]; m_got = 1; end
                else m_err = 1'b1;
            end else begin
                m_rows[m_got-1] = d;
                m_got = m_got + 1;
                if (m_got == NR + 1) begin
                    m_got = 0;
                    if (m_idx < 16'(MF)) begin m_busy = 2; m_strobe = 32'd1 << m_idx; end
                    else m_err = 1'b1;
                end
            end
        end
        m_ready = (m_busy == 0);
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_outputs();
        chk("s_ready",     128'(s_ready),     128'(m_ready));
        chk("FrameStrobe", 128'(FrameStrobe), 128'(m_strobe));
        chk("frame_done",  128'(frame_done),  128'(m_done));
        chk("frame_err",   128'(frame_err),   128'(m_err));
        chk("frame_count", 128'(frame_count), 128'(m_count));
        chk("FrameData",   FrameData, {m_rows[3], m_rows[2], m_rows[1], m_rows[0]});
    endtask

    // One clock: drive at negedge, model at posedge, compare at next negedge.
    task automatic cycle(input logic v, input logic [31:0] d);
        s_valid = v; s_data = d;
        @(posedge UserCLK);
        model_edge(v, d);
        @(negedge UserCLK);
        check_outputs();
    endtask

    logic [31:0] wq[$];

    task automatic send_q(input bit gaps);
        for (int i = 0; i < wq.size(); i++) begin
            bit   accepted;
            int   guard;
            logic v, rdy;
            accepted = 1'b0; guard = 0;
            while (!accepted) begin
                v   = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
                rdy = m_ready;
                cycle(v, v ? wq[i] : $urandom);
                accepted = v && rdy;
                guard++;
                if (!accepted && guard > 64) begin
                    n_vec++; n_err++;
                    $display("FAIL send_timeout: word %0d not accepted after %0d cycles", i, guard);
                    accepted = 1'b1;
                end
            end
        end
    endtask

    typedef struct {
        logic        v;
        logic [31:0] d;
        logic        rdy;
        logic [31:0] stb;
        logic        done;
        logic        err;
        logic [15:0] cnt;
    } vec_t;

    vec_t tbl[16];

    initial begin
        logic [15:0] cnt_snap;
        int          kind;

        tbl[0]  = '{1'b0, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b0, 1'b0, 16'd0};
        tbl[1]  = '{1'b1, 32'hFAB1_0003, 1'b1, 32'h0000_0000, 1'b0, 1'b0, 16'd0};
        tbl[2]  = '{1'b1, 32'h1111_1111, 1'b1, 32'h0000_0000, 1'b0, 1'b0, 16'd0};
        tbl[3]  = '{1'b1, 32'h2222_2222, 1'b1, 32'h0000_0000, 1'b0, 1'b0, 16'd0};
        tbl[4]  = '{1'b1, 32'h3333_3333, 1'b1, 32'h0000_0000, 1'b0, 1'b0, 16'd0};
        tbl[5]  = '{1'b1, 32'h4444_4444, 1'b0, 32'h0000_0008, 1'b0, 1'b0, 16'd0};
        tbl[6]  = '{1'b1, 32'h1234_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 16'd1};
        tbl[7]  = '{1'b1, 32'h1234_0000, 1'b1, 32'h0000_0000, 1'b0, 1'b0, 16'd1};
        tbl[8]  = '{1'b1, 32'h1234_0000, 1'b1, 32'h0000_0000, 1'b0, 1'b1, 16'd1};
        tbl[9]  = '{1'b1, 32'hFAB1_001F, 1'b1, 32'h0000_0000, 1'b0, 1'b0, 16'd1};
        tbl[10] = '{1'b1, 32'hAAAA_0001, 1'b1, 32'h0000_0000, 1'b0, 1'b0, 16'd1};
        tbl[11] = '{1'b1, 32'hBBBB_0002, 1'b1, 32'h0000_0000, 1'b0, 1'b0, 16'd1};
        tbl[12] = '{1'b1, 32'hCCCC_0003, 1'b1, 32'h0000_0000, 1'b0, 1'b0, 16'd1};
        tbl[13] = '{1'b1, 32'hDDDD_0004, 1'b0, 32'h8000_0000, 1'b0, 1'b0, 16'd1};
        tbl[14] = '{1'b0, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 16'd2};
        tbl[15] = '{1'b0, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b0, 1'b0, 16'd2};

        // Reset state
        resetn = 1'b0; s_valid = 1'b0; s_data = 32'h0;
        model_reset();
        repeat (2) @(negedge UserCLK);
        check_outputs();
        resetn = 1'b1;

        // T1/T2 plus header spacing: directed table
        for (int i = 0; i < 16; i++) begin
            cycle(tbl[i].v, tbl[i].d);
            chk("tbl_ready",  128'(s_ready),     128'(tbl[i].rdy));
            chk("tbl_strobe", 128'(FrameStrobe), 128'(tbl[i].stb));
            chk("tbl_done",   128'(frame_done),  128'(tbl[i].done));
            chk("tbl_err",    128'(frame_err),   128'(tbl[i].err));
            chk("tbl_count",  128'(frame_count), 128'(tbl[i].cnt));
            if (i == 5)
                chk("t1_framedata", FrameData,
                    {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111});
        end

        // T3: out-of-range index consumes its rows and only reports an error
        cnt_snap = m_count;
        wq = '{32'hFAB1_0020, 32'h0101_0101, 32'h0202_0202, 32'h0303_0303, 32'h0404_0404};
        send_q(1'b0);
        chk("t3_err",    128'(frame_err),   128'd1);
        chk("t3_strobe", 128'(FrameStrobe), 128'd0);
        chk("t3_count",  128'(frame_count), 128'(cnt_snap));
        cycle(1'b0, 32'h0);

        // T4: T1 frame with random valid gaps
        wq = '{32'hFAB1_0003, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444};
        send_q(1'b1);
        chk("t4_strobe", 128'(FrameStrobe), 128'h8);
        chk("t4_framedata", FrameData,
            {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111});
        cycle(1'b0, 32'h0);
        chk("t4_hold_ready", 128'(s_ready), 128'd0);

        // T5: reset asserted right as STROBE is entered
        wq = '{32'hFAB1_0005, 32'h5555_0000, 32'h5555_0001, 32'h5555_0002};
        send_q(1'b0);
        s_valid = 1'b1; s_data = 32'h5555_0003;
        @(posedge UserCLK);
        model_edge(1'b1, 32'h5555_0003);
        #1;
        chk("t5_strobe_pre", 128'(FrameStrobe), 128'h20);
        resetn = 1'b0;
        #1;
        model_reset();
        chk("t5_strobe_async", 128'(FrameStrobe), 128'd0);
        chk("t5_count",        128'(frame_count), 128'd0);
        chk("t5_done",         128'(frame_done),  128'd0);
        s_valid = 1'b0;
        @(negedge UserCLK);
        check_outputs();
        resetn = 1'b1;
        cycle(1'b0, 32'h0);
        wq = '{32'hFAB1_0009, 32'h9000_0000, 32'h9000_0001, 32'h9000_0002, 32'h9000_0003};
        send_q(1'b0);
        chk("t5_refill_strobe", 128'(FrameStrobe), 128'h200);
        cycle(1'b0, 32'h0);
        cycle(1'b0, 32'h0);

        // T6: frame counter wraps from 16'hFFFF
        force dut.frame_count_r = 16'hFFFF;
        m_count = 16'hFFFF;
        cycle(1'b0, 32'h0);
        release dut.frame_count_r;
        cycle(1'b0, 32'h0);
        wq = '{32'hFAB1_0000, 32'h6000_0000, 32'h6000_0001, 32'h6000_0002, 32'h6000_0003};
        send_q(1'b0);
        cycle(1'b0, 32'h0);
        chk("t6_done",  128'(frame_done),  128'd1);
        chk("t6_count", 128'(frame_count), 128'd0);

        // Randomized frames: good, bad magic, bad index; random valid gaps
        for (int f = 0; f < 60; f++) begin
            kind = $urandom_range(0, 9);
            wq.delete();
            if (kind == 0) begin
                wq.push_back({16'hDEAD, 16'($urandom)});
            end else begin
                if (kind == 1) wq.push_back({16'hFAB1, 16'($urandom_range(32, 65535))});
                else           wq.push_back({16'hFAB1, 16'($urandom_range(0, 31))});
                for (int r = 0; r < NR; r++) wq.push_back($urandom);
            end
            send_q(1'b1);
        end
        repeat (3) cycle(1'b0, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
